// File: rtl/pid_cfg_sequencer.sv
// pid_cfg_sequencer
// Sits between the host register interface and pid_core. Host writes land in
// shadow registers. A commit copies the whole shadow set to the live outputs
// in a single edge, aligned to a PID sample strobe. After that the setpoint
// slews toward its target by at most one step per strobe. pid_clr_o pulses
// when the loop goes from disabled to enabled.

module pid_cfg_sequencer (
  input  logic               clk,
  input  logic               rst_n,
  // host write channel
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [2:0]         cfg_addr_i,
  input  logic [15:0]        cfg_data_i,
  // sequencing controls
  input  logic               commit_i,
  input  logic               strobe_i,
  output logic               busy_o,
  // live parameter set seen by pid_core
  output logic signed [15:0] kp_o,
  output logic signed [15:0] kd_o,
  output logic signed [15:0] ki_o,
  output logic signed [15:0] sp_o,
  output logic [3:0]         alpha_o,
  output logic [13:0]        decimate_o,
  output logic               enable_o,
  output logic               pid_clr_o
);

  // Shadow register addresses.
  localparam logic [2:0] ADDR_KP    = 3'd0;
  localparam logic [2:0] ADDR_KD    = 3'd1;
  localparam logic [2:0] ADDR_KI    = 3'd2;
  localparam logic [2:0] ADDR_SP    = 3'd3;
  localparam logic [2:0] ADDR_ALPHA = 3'd4;
  localparam logic [2:0] ADDR_DEC   = 3'd5;
  localparam logic [2:0] ADDR_CTRL  = 3'd6;
  localparam logic [2:0] ADDR_STEP  = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_STROBE,
    APPLY,
    RAMP
  } state_t;

  // Staged copy of the full parameter set written by the host.
  typedef struct packed {
    logic signed [15:0] kp;
    logic signed [15:0] kd;
    logic signed [15:0] ki;
    logic signed [15:0] sp;
    logic [3:0]         alpha;
    logic [13:0]        decimate;
    logic               enable;
    logic [14:0]        step;
  } shadow_t;

  state_t  state;
  state_t  state_d;
  shadow_t shadow;

  logic               cfg_write;
  logic               step_is_zero;
  logic               at_target;
  logic signed [16:0] sp_diff;
  logic [16:0]        sp_dist;
  logic               ramp_reaches;
  logic [15:0]        sp_stepped;
  logic signed [15:0] sp_ramp_next;
  logic [13:0]        decimate_eff;

  // cfg_ready_o is a registered copy of (state == IDLE), so it can gate
  // acceptance directly.
  assign cfg_write = cfg_valid_i && cfg_ready_o;

  // Capture host writes into the shadow set.
  // NOTE: every register here, shadows included, has an explicit reset value
  // because a commit straight after reset must apply a known parameter set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow.kp       <= '0;
      shadow.kd       <= '0;
      shadow.ki       <= '0;
      shadow.sp       <= '0;
      shadow.alpha    <= '0;
      shadow.decimate <= 14'd1;
      shadow.enable   <= 1'b0;
      shadow.step     <= '0;
    end else if (cfg_write) begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // register samples the values from before this edge.
      case (cfg_addr_i)
        ADDR_KP:    shadow.kp       <= $signed(cfg_data_i);
        ADDR_KD:    shadow.kd       <= $signed(cfg_data_i);
        ADDR_KI:    shadow.ki       <= $signed(cfg_data_i);
        ADDR_SP:    shadow.sp       <= $signed(cfg_data_i);
        ADDR_ALPHA: shadow.alpha    <= cfg_data_i[3:0];
        ADDR_DEC:   shadow.decimate <= cfg_data_i[13:0];
        ADDR_CTRL:  shadow.enable   <= cfg_data_i[0];
        ADDR_STEP:  shadow.step     <= cfg_data_i[14:0];
        default:    shadow.kp       <= shadow.kp;
      endcase
    end
  end

  // Slew arithmetic. The difference is formed in 17 bits so a full-scale
  // swing (32767 -> -32768) neither wraps nor overshoots.
  always_comb begin
    // NOTE: each combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    sp_diff      = $signed({shadow.sp[15], shadow.sp}) - $signed({sp_o[15], sp_o});
    sp_dist      = sp_diff[16] ? 17'(-sp_diff) : 17'(sp_diff);
    ramp_reaches = (sp_dist <= {2'b00, shadow.step});
    sp_stepped   = sp_diff[16] ? (sp_o - {1'b0, shadow.step})
                               : (sp_o + {1'b0, shadow.step});
    sp_ramp_next = ramp_reaches ? shadow.sp : $signed(sp_stepped);
  end

  // Decisions taken in APPLY, and the decimate clamp (0 is loaded as 1).
  always_comb begin
    step_is_zero = (shadow.step == 15'd0);
    at_target    = (shadow.sp == sp_o);
    decimate_eff = (shadow.decimate == 14'd0) ? 14'd1 : shadow.decimate;
  end

  // Next-state logic for the commit / apply / ramp sequence.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (commit_i) state_d = WAIT_STROBE;
      end
      WAIT_STROBE: begin
        // A strobe in the commit cycle was seen while still IDLE, so only
        // strobes after entry can get here.
        if (strobe_i) state_d = APPLY;
      end
      APPLY: begin
        if (step_is_zero || at_target) state_d = IDLE;
        else                           state_d = RAMP;
      end
      RAMP: begin
        if (strobe_i && ramp_reaches) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus all registered outputs: handshake, busy, live set,
  // setpoint ramp and the integrator-clear pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cfg_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      kp_o        <= '0;
      kd_o        <= '0;
      ki_o        <= '0;
      sp_o        <= '0;
      alpha_o     <= '0;
      decimate_o  <= 14'd1;
      enable_o    <= 1'b0;
      pid_clr_o   <= 1'b0;
    end else begin
      state       <= state_d;
      cfg_ready_o <= (state_d == IDLE);
      busy_o      <= (state_d != IDLE);
      pid_clr_o   <= 1'b0;

      if (state == APPLY) begin
        kp_o       <= shadow.kp;
        kd_o       <= shadow.kd;
        ki_o       <= shadow.ki;
        alpha_o    <= shadow.alpha;
        decimate_o <= decimate_eff;
        enable_o   <= shadow.enable;
        // Clear history only on a fresh enable, not on re-commits while running.
        pid_clr_o  <= shadow.enable && !enable_o;
        if (step_is_zero) sp_o <= shadow.sp;
      end

      // One bounded step per strobe; the APPLY-cycle strobe is not used.
      if (state == RAMP && strobe_i) sp_o <= sp_ramp_next;
    end
  end

endmodule

// File: tb/tb_pid_cfg_sequencer.sv
// Self-checking bench for pid_cfg_sequencer. Stimulus pushes the expected
// live parameter set, tagged with the cycle it must appear in, onto a queue.
// A monitor pops and compares every time any live output changes.

module tb_pid_cfg_sequencer;

  logic               clk;
  logic               rst_n;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [2:0]         cfg_addr;
  logic [15:0]        cfg_data;
  logic               commit;
  logic               strobe;
  logic               busy;
  logic signed [15:0] kp, kd, ki, sp;
  logic [3:0]         alpha;
  logic [13:0]        decimate;
  logic               enable;
  logic               pid_clr;

  typedef struct packed {
    logic [15:0] kp;
    logic [15:0] kd;
    logic [15:0] ki;
    logic [15:0] sp;
    logic [3:0]  alpha;
    logic [13:0] dec;
    logic        en;
    logic        clr;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t v;
  } exp_t;

  localparam snap_t RST_SNAP = '{16'h0, 16'h0, 16'h0, 16'h0, 4'h0, 14'd1, 1'b0, 1'b0};

  exp_t  exp_q[$];
  snap_t model;
  snap_t mon_prev;
  snap_t mon_cur;
  exp_t  mon_e;
  int    total;
  int    bad;
  int    cyc;

  pid_cfg_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_addr_i  (cfg_addr),
    .cfg_data_i  (cfg_data),
    .commit_i    (commit),
    .strobe_i    (strobe),
    .busy_o      (busy),
    .kp_o        (kp),
    .kd_o        (kd),
    .ki_o        (ki),
    .sp_o        (sp),
    .alpha_o     (alpha),
    .decimate_o  (decimate),
    .enable_o    (enable),
    .pid_clr_o   (pid_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic snap_t dut_snap();
    return '{kp, kd, ki, sp, alpha, decimate, enable, pid_clr};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: any change of the live set must match the next queued entry,
  // both in value and in the cycle it appears.
  always @(negedge clk) begin
    mon_cur = dut_snap();
    if (!rst_n) begin
      mon_prev = mon_cur;
    end else if (mon_cur != mon_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_change", 96'(mon_cur), 96'(mon_prev));
      end else begin
        mon_e = exp_q.pop_front();
        check("live_set", 96'(mon_cur), 96'(mon_e.v));
        check("live_cycle", 96'(mon_e.cyc), 96'(cyc));
      end
      mon_prev = mon_cur;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int c);
    exp_t e;
    e.cyc = c;
    e.v   = model;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cfg_addr  = a;
    cfg_data  = d;
    cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step(1);
    commit = 1'b0;
  endtask

  task automatic pulse_strobe();
    strobe = 1'b1;
    step(1);
    strobe = 1'b0;
  endtask

  // One ramp strobe in RAMP: the new setpoint appears the following cycle.
  task automatic ramp_strobe(input logic [15:0] v);
    model.sp = v;
    expect_at(cyc + 1);
    pulse_strobe();
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      step(1);
      n++;
    end
    check("wait_idle", 96'(busy), 96'd0);
  endtask

  initial begin
    int s;
    total     = 0;
    bad       = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    commit    = 1'b0;
    strobe    = 1'b0;
    model     = RST_SNAP;
    step(3);
    rst_n = 1'b1;
    step(1);

    // Reset values
    check("reset_live", 96'(dut_snap()), 96'(RST_SNAP));
    check("reset_ready", 96'(cfg_ready), 96'd1);
    check("reset_busy", 96'(busy), 96'd0);

    // Atomic commit with enable 0->1: strobe 5 cycles after the commit
    wr(3'd0, 16'h3FFF);
    wr(3'd1, 16'h1FFF);
    wr(3'd2, 16'h1FFF);
    wr(3'd4, 16'h0002);
    wr(3'd5, 16'h0002);
    wr(3'd6, 16'h0001);
    do_commit();
    check("commit_busy", 96'(busy), 96'd1);
    check("commit_ready", 96'(cfg_ready), 96'd0);
    step(4);
    s = cyc;
    model = '{16'h3FFF, 16'h1FFF, 16'h1FFF, 16'h0000, 4'd2, 14'd2, 1'b1, 1'b1};
    expect_at(s + 2);
    model.clr = 1'b0;
    expect_at(s + 3);
    pulse_strobe();
    wait_idle(20);

    // No strobe: stays waiting, refuses writes; then decimate 0 -> 1,
    // and enable already 1 gives no clear pulse
    wr(3'd5, 16'h0000);
    do_commit();
    step(50);
    cfg_addr  = 3'd0;
    cfg_data  = 16'h1234;
    cfg_valid = 1'b1;
    check("wait_ready", 96'(cfg_ready), 96'd0);
    step(1);
    cfg_valid = 1'b0;
    step(49);
    check("nostrobe_busy", 96'(busy), 96'd1);
    check("nostrobe_ready", 96'(cfg_ready), 96'd0);
    s = cyc;
    model.dec = 14'd1;
    expect_at(s + 2);
    pulse_strobe();
    wait_idle(20);

    // Ramp up 0 -> 10 by 4; a strobe in the APPLY cycle must be ignored
    wr(3'd3, 16'd10);
    wr(3'd7, 16'd4);
    do_commit();
    strobe = 1'b1;
    step(2);
    strobe = 1'b0;
    step(2);
    ramp_strobe(16'd4);
    step(2);
    ramp_strobe(16'd8);
    check("ramp_busy", 96'(busy), 96'd1);
    step(2);
    ramp_strobe(16'd10);
    check("ramp_end_busy", 96'(busy), 96'd0);
    check("ramp_end_ready", 96'(cfg_ready), 96'd1);

    // Write in the commit cycle is included; step 0 loads the target
    // directly; a strobe in the commit cycle does not count
    wr(3'd7, 16'd0);
    cfg_addr  = 3'd3;
    cfg_data  = 16'h7FFF;
    cfg_valid = 1'b1;
    commit    = 1'b1;
    strobe    = 1'b1;
    step(1);
    cfg_valid = 1'b0;
    commit    = 1'b0;
    strobe    = 1'b0;
    step(2);
    s = cyc;
    model.sp = 16'h7FFF;
    expect_at(s + 2);
    pulse_strobe();
    wait_idle(20);

    // Ramp down 32767 -> -32768 by 32767: 0, -32767, -32768
    wr(3'd3, 16'h8000);
    wr(3'd7, 16'h7FFF);
    do_commit();
    pulse_strobe();
    step(1);
    for (int i = 0; i < 3; i++) begin
      step(2);
      case (i)
        0:       ramp_strobe(16'h0000);
        1:       ramp_strobe(16'h8001);
        default: ramp_strobe(16'h8000);
      endcase
    end
    wait_idle(5);

    // Reset mid-WAIT_STROBE aborts to reset values, shadows included
    do_commit();
    step(3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_live", 96'(dut_snap()), 96'(RST_SNAP));
    check("midrst_ready", 96'(cfg_ready), 96'd1);
    check("midrst_busy", 96'(busy), 96'd0);
    step(2);
    #3 rst_n = 1'b1;
    step(1);
    model = RST_SNAP;
    do_commit();
    pulse_strobe();
    wait_idle(20);
    check("post_rst_live", 96'(dut_snap()), 96'(RST_SNAP));
    step(5);
    check("queue_drained", 96'(exp_q.size()), 96'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
